data_mem_responder: RTL

- Responder end of the per-lane data-memory handshake driven by a SIMD unit's LSUs (mem_read_valid/mem_write_valid/mem_addr/mem_write_data → data_mem_read_ack/data_mem_write_ack/mem_read_data).
- Owns a word-addressed data store and serves at most NUM_CHANNELS lane requests concurrently.
- Each request completes after a fixed access latency; lanes are picked by round-robin arbitration.
- Sits between one SIMD unit and its data memory; a host load port lets the testbench or dispatcher preload kernel data.

---
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Multi-channel responder for per-lane LSU load/store handshakes.
// Owns a word-addressed store, round-robin arbitration, fixed access latency.
module data_mem_responder #(
    parameter int DATA_WIDTH          = 64,
    parameter int DATA_REG_ADDR_WIDTH = 7,
    parameter int LANE_WIDTH          = 16,
    parameter int NUM_CHANNELS        = 4,
    parameter int ACCESS_LATENCY      = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [LANE_WIDTH-1:0]                          mem_read_valid,
    input  logic [LANE_WIDTH-1:0]                          mem_write_valid,
    input  logic [LANE_WIDTH-1:0][DATA_REG_ADDR_WIDTH-1:0] mem_addr,
    input  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0]          mem_write_data,
    output logic [LANE_WIDTH-1:0]                          data_mem_read_ack,
    output logic [LANE_WIDTH-1:0]                          data_mem_write_ack,
    output logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0]          mem_read_data,
    input  logic                                           host_write_en,
    input  logic [DATA_REG_ADDR_WIDTH-1:0]                 host_addr,
    input  logic [DATA_WIDTH-1:0]                          host_write_data,
    output logic                                           busy
);

    localparam int LANE_IDX_W = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
    localparam int CNT_W      = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
    localparam int DEPTH      = 2 ** DATA_REG_ADDR_WIDTH;
    localparam logic [CNT_W-1:0]      CNT_INIT   = CNT_W'(ACCESS_LATENCY - 1);
    localparam logic [LANE_IDX_W:0]   LANE_COUNT = (LANE_IDX_W + 1)'(LANE_WIDTH);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE  = LANE_IDX_W'(LANE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } chan_state_t;

    logic [DATA_WIDTH-1:0]                 store_reg [DEPTH];
    logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] rdata_reg;
    logic [LANE_IDX_W-1:0]                 rr_ptr_reg;
    logic [LANE_IDX_W-1:0]                 rr_ptr_next;

    logic [NUM_CHANNELS-1:0]        chan_active;
    logic [NUM_CHANNELS-1:0]        chan_fire;
    logic [NUM_CHANNELS-1:0]        chan_is_read;
    logic [NUM_CHANNELS-1:0]        chan_ack_rd;
    logic [NUM_CHANNELS-1:0]        chan_ack_wr;
    logic [LANE_IDX_W-1:0]          chan_lane  [NUM_CHANNELS];
    logic [DATA_REG_ADDR_WIDTH-1:0] chan_addr  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]          chan_wdata [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] grant;
    logic [LANE_IDX_W-1:0]   grant_lane [NUM_CHANNELS];
    logic [LANE_WIDTH-1:0]   assigned;
    logic [LANE_WIDTH-1:0]   pending;
    logic [LANE_WIDTH-1:0]   taken;
    logic [LANE_IDX_W:0]     search_wide;
    logic [LANE_IDX_W-1:0]   search_lane;

    // A lane stays owned while its channel is in ACK, so it cannot be
    // regranted on the same edge that channel returns to IDLE.
    always_comb begin
        assigned = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (chan_active[c]) assigned[chan_lane[c]] = 1'b1;
        end
        pending = (mem_read_valid | mem_write_valid) & ~assigned;
    end

    always_comb begin
        taken       = '0;
        rr_ptr_next = rr_ptr_reg;
        search_wide = '0;
        search_lane = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant[c]      = 1'b0;
            grant_lane[c] = '0;
            if (!chan_active[c]) begin
                for (int k = 0; k < LANE_WIDTH; k++) begin
                    search_wide = {1'b0, rr_ptr_reg} + (LANE_IDX_W + 1)'(k);
                    if (search_wide >= LANE_COUNT) search_wide = search_wide - LANE_COUNT;
                    search_lane = search_wide[LANE_IDX_W-1:0];
                    if (!grant[c] && pending[search_lane] && !taken[search_lane]) begin
                        grant[c]             = 1'b1;
                        grant_lane[c]        = search_lane;
                        taken[search_lane]   = 1'b1;
                        rr_ptr_next          = (search_lane == LAST_LANE) ? '0 : search_lane + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        chan_state_t                    state_reg;
        chan_state_t                    state_next;
        logic [CNT_W-1:0]               cnt_reg;
        logic [LANE_IDX_W-1:0]          lane_reg;
        logic [DATA_REG_ADDR_WIDTH-1:0] addr_reg;
        logic [DATA_WIDTH-1:0]          wdata_reg;
        logic                           is_read_reg;
        logic                           held_valid;

        assign held_valid = is_read_reg ? mem_read_valid[lane_reg] : mem_write_valid[lane_reg];

        always_comb begin
            state_next = state_reg;
            case (state_reg)
                IDLE:    if (grant[gi]) state_next = ACCESS;
                ACCESS:  if (cnt_reg == '0) state_next = ACK;
                ACK:     if (!held_valid) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        // A request with both valids high is taken as a read.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_reg   <= IDLE;
                cnt_reg     <= '0;
                lane_reg    <= '0;
                addr_reg    <= '0;
                wdata_reg   <= '0;
                is_read_reg <= 1'b0;
            end else begin
                state_reg <= state_next;
                if (state_reg == IDLE && grant[gi]) begin
                    lane_reg    <= grant_lane[gi];
                    addr_reg    <= mem_addr[grant_lane[gi]];
                    wdata_reg   <= mem_write_data[grant_lane[gi]];
                    is_read_reg <= mem_read_valid[grant_lane[gi]];
                    cnt_reg     <= CNT_INIT;
                end else if (state_reg == ACCESS && cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end

        assign chan_active[gi]  = (state_reg != IDLE);
        assign chan_fire[gi]    = (state_reg == ACCESS) && (cnt_reg == '0);
        assign chan_is_read[gi] = is_read_reg;
        assign chan_ack_rd[gi]  = (state_reg == ACK) && is_read_reg;
        assign chan_ack_wr[gi]  = (state_reg == ACK) && !is_read_reg;
        assign chan_lane[gi]    = lane_reg;
        assign chan_addr[gi]    = addr_reg;
        assign chan_wdata[gi]   = wdata_reg;
    end

    // Host write first, then channels ascending: a higher channel's commit
    // overrides both the host and lower channels on the same address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) store_reg[i] <= '0;
            rdata_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (host_write_en) store_reg[host_addr] <= host_write_data;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (chan_fire[c] && !chan_is_read[c]) store_reg[chan_addr[c]] <= chan_wdata[c];
                if (chan_fire[c] && chan_is_read[c]) rdata_reg[chan_lane[c]] <= store_reg[chan_addr[c]];
            end
        end
    end

    always_comb begin
        data_mem_read_ack  = '0;
        data_mem_write_ack = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (chan_ack_rd[c]) data_mem_read_ack[chan_lane[c]] = 1'b1;
            if (chan_ack_wr[c]) data_mem_write_ack[chan_lane[c]] = 1'b1;
        end
    end

    assign mem_read_data = rdata_reg;
    assign busy          = |chan_active;

endmodule
